fp16_cvt_arbiter: RTL and testbench
===================================

// Module: fp16_cvt_arbiter
// PURPOSE
//  Shares one fp16->fp32 conversion datapath between N_REQ requesters using round-robin arbitration.
//  Each requester presents a 16-bit half-precision value with valid/ready handshakes.
//  The winner's value is converted and held in a one-deep output register, tagged with the requester index.
//  Sits between the vector-unpack front end and the fp32 execution lanes.
// PARAMETERS
//  N_REQ  4                  number of requesters (2..16)
//  ID_W   $clog2(N_REQ)      width of out_id (derived, not overridden)
// PORTS
//  clk        in   1          rising-edge clock; single clock domain
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   N_REQ      per-requester request valid
//  req_data   in   16*N_REQ   fp16 operand; requester i occupies bits [16*i+15:16*i]
//  req_ready  out  N_REQ      one-hot grant/accept; at most one bit set per cycle
//  out_valid  out  1          converted result valid
//  out_data   out  32         fp32 result
//  out_id     out  ID_W       index of the requester that produced out_data
//  out_ready  in   1          downstream accepts the result
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at a clk edge): out_valid=0, out_data=0, out_id=0, rr_ptr=N_REQ-1.
//    req_ready=0 while rst=1. Reset clears any pending result mid-operation; that result is dropped.
//  - can_load = !out_valid || out_ready. req_ready is combinational: one-hot on the granted index when can_load, else all zero.
//  - Arbitration: scan from rr_ptr+1, wrapping modulo N_REQ. Grant the first index with req_valid set.
//    On a transfer (req_valid[g] && req_ready[g]), set rr_ptr=g. With no transfer, rr_ptr holds.
//  - Transfer: on the same edge, out_data <= cvt(req_data[g]), out_id <= g, out_valid <= 1.
//    Latency is 1 cycle from accept to out_valid.
//  - Drain: out_valid && out_ready with no new transfer -> out_valid <= 0; out_data and out_id hold their last values.
//  - Simultaneous drain and load: the register is overwritten in the same cycle. Sustained throughput is 1 result per cycle.
//  - Backpressure: while out_valid && !out_ready, out_data and out_id are stable and all req_ready=0.
//  - Requesters must hold req_valid and req_data stable until accepted. The arbiter does not latch unaccepted requests.
//  - cvt() fields:
//    - sign passes through unchanged.
//    - exp16 in 1..30 -> exp32 = exp16 + 112 (8-bit); mant32 = {mant16, 13'b0}.
//    - exp16 == 31 -> exp32 = 255; mant32 = {mant16, 13'b0}. Inf stays Inf; NaN payload is preserved.
//    - exp16 == 0 && mant16 == 0 -> signed zero.
//    - exp16 == 0 && mant16 != 0 (subnormal) -> per FP16_SUBNORM_EN, below.
// CONFIGURATION
//  FP16_SUBNORM_EN defined:
//    - Subnormals are normalized exactly. lz = leading zeros of mant16 (0..9).
//    - exp32 = 113 - (lz+1); mant32 = {mant16 << (lz+1), 13'b0}[22:0].
//    - All fp16 subnormals are exactly representable in fp32.
//  FP16_SUBNORM_EN undefined:
//    - Subnormal inputs flush to signed zero: fp32 = {sign, 31'b0}.
// STRUCTURE
//  - Shared package fp_cvt_pkg holds:
//    - FP16_EXP_W=5, FP16_MAN_W=10, FP32_EXP_W=8, FP32_MAN_W=23
//    - BIAS_DIFF=8'd112, EXP32_MAX=8'd255
//    - typedefs fp16_t and fp32_t, as packed structs {sign, exp, man}
//  - Sub-module fp16_to_fp32_core: purely combinational cvt(), including the optional LZC normalizer.
//    It is instantiated once after the grant mux.
//  - Top level contains the round-robin pointer, grant logic, data mux and output register.
// TESTING
//  - Basic conversions, one at a time on req 0:
//    - 0x3C00 -> out_data 0x3F800000, out_id 0, one cycle after accept.
//    - 0xC000 -> 0xC0000000.
//    - 0x7C00 -> 0x7F800000.
//    - 0x7E01 -> 0x7FC02000.
//  - Subnormal 0x0001:
//    - with FP16_SUBNORM_EN -> 0x33800000.
//    - without it -> 0x00000000.
//    - 0x8000 -> 0x80000000 in both builds.
//  - Round robin: all 4 req_valid held high with out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
//  - Backpressure: out_ready=0 for 5 cycles with a result pending -> req_ready all zero; out_data/out_id stable; no grant pointer movement.
//  - Reset mid-stream: assert rst with out_valid=1 -> the next cycle shows out_valid=0 and out_id=0, and the first post-reset grant goes to req 0.
//  - Sparse requests: only req 2 valid after req 3 was last served -> req 2 granted immediately, with no idle cycle for the empty slots.

Source files
------------

// File: rtl/fp_cvt_pkg.sv
// Shared floating-point field widths, conversion constants and packed
// views of half- and single-precision words used by the fp16 converter.
package fp_cvt_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [FP32_EXP_W-1:0] BIAS_DIFF = 8'd112;
  localparam logic [FP32_EXP_W-1:0] EXP32_MAX = 8'd255;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp16_to_fp32_core.sv
// Purely combinational fp16 -> fp32 widening conversion.
// Build option FP16_SUBNORM_EN: when defined, fp16 subnormals are normalized
// exactly through a leading-zero count; otherwise they flush to signed zero.
module fp16_to_fp32_core
  import fp_cvt_pkg::*;
(
  input  logic [15:0] half_val,
  output logic [31:0] single_val
);

  fp16_t h;
  fp32_t f;

  assign h          = half_val;
  assign single_val = f;

`ifdef FP16_SUBNORM_EN
  logic [3:0]            lz;
  logic                  lz_found;
  logic [FP16_MAN_W-1:0] norm_man;

  // Leading-zero count of the subnormal mantissa, scanning from the MSB down
  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = FP16_MAN_W - 1; i >= 0; i--) begin
      if (!lz_found && h.man[i]) begin
        lz       = 4'(FP16_MAN_W - 1 - i);
        lz_found = 1'b1;
      end
    end
  end

  // Shifting past the leading one makes it the hidden bit of the fp32 result
  assign norm_man = h.man << (lz + 4'd1);
`endif

  // Field-by-field widening: rebias normals, keep Inf/NaN payloads, handle zero/subnormal
  always_comb begin
    f.sign = h.sign;
    f.exp  = '0;
    f.man  = '0;
    if (h.exp == '1) begin
      f.exp = EXP32_MAX;
      f.man = {h.man, {(FP32_MAN_W - FP16_MAN_W){1'b0}}};
    end else if (h.exp != '0) begin
      f.exp = BIAS_DIFF + {{(FP32_EXP_W - FP16_EXP_W){1'b0}}, h.exp};
      f.man = {h.man, {(FP32_MAN_W - FP16_MAN_W){1'b0}}};
    end else if (h.man != '0) begin
`ifdef FP16_SUBNORM_EN
      f.exp = BIAS_DIFF - {4'b0000, lz};
      f.man = {norm_man, {(FP32_MAN_W - FP16_MAN_W){1'b0}}};
`else
      f.exp = '0;
      f.man = '0;
`endif
    end
  end

endmodule

// File: rtl/fp16_cvt_arbiter.sv
// Round-robin arbiter sharing one fp16 -> fp32 converter among N_REQ
// requesters, with a one-deep output register tagged by requester index.
// Build option FP16_SUBNORM_EN (passed through to fp16_to_fp32_core):
// exact subnormal normalization when defined, flush-to-zero otherwise.
module fp16_cvt_arbiter
  import fp_cvt_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  output logic [31:0]         out_data,
  output logic [ID_W-1:0]     out_id,
  input  logic                out_ready
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            can_load;
  logic            transfer;
  logic [15:0]     mux_data;
  logic [31:0]     cvt_data;
  int              cand;

  assign can_load = !out_valid || out_ready;
  assign transfer = |(req_valid & req_ready);

  // Round-robin search starting just after the last served requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // One-hot accept on the winner, only when the output register can take a result
  always_comb begin
    req_ready = '0;
    if (!rst && can_load && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Select the winning operand ahead of the single shared converter
  always_comb begin
    mux_data = req_data[16*int'(grant_idx) +: 16];
  end

  fp16_to_fp32_core u_core (
    .half_val   (mux_data),
    .single_val (cvt_data)
  );

  // Output register and pointer: load on transfer, clear valid on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= ID_W'(N_REQ - 1);
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= cvt_data;
      out_id    <= grant_idx;
      rr_ptr    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp16_cvt_arbiter.sv
// Scoreboard bench for fp16_cvt_arbiter: directed spec cases followed by
// randomized traffic, checked against a real-arithmetic conversion model.
module tb_fp16_cvt_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [31:0] data;
    int          id;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [31:0]     out_data;
  logic [1:0]      out_id;
  logic            out_ready;

  fp16_cvt_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  int          checkCount = 0;
  int          passCount  = 0;
  exp_t        sb[$];
  logic        pv[N];
  logic [15:0] pd[N];
  int          lastServed;
  logic        modelValid;
  logic [N-1:0] lastReady;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference conversion: decode the fp16 value numerically, then re-encode via a double
  function automatic logic [31:0] refCvt(input logic [15:0] h);
    logic        s;
    int          e;
    int          m;
    int          ex;
    real         mag;
    logic [63:0] bits;
    s = h[15];
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) return {s, 8'hFF, h[9:0], 13'b0};
    if (e == 0 && m == 0) return {s, 31'b0};
`ifndef FP16_SUBNORM_EN
    if (e == 0) return {s, 31'b0};
`endif
    if (e == 0) mag = real'(m) * pow2(-24);
    else        mag = real'(1024 + m) * pow2(e - 25);
    bits = $realtobits(mag);
    ex   = int'(bits[62:52]) - 1023 + 127;
    return {s, ex[7:0], bits[51:29]};
  endfunction

  function automatic logic [15:0] randHalf();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 4))
      0: v[14:10] = 5'd0;
      1: v[14:10] = 5'd31;
      default: ;
    endcase
    return v;
  endfunction

  // One clock of stimulus; the reference arbiter picks the expected winner
  task automatic applyStimulus(input logic r, input logic ordy);
    int          g;
    logic [N-1:0] expReady;
    @(negedge clk);
    rst       = r;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pv[i];
      req_data[16*i +: 16]  = pd[i];
    end
    #1;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && pv[(lastServed + k) % N]) g = (lastServed + k) % N;
    expReady = '0;
    if (!r && (!modelValid || ordy) && g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    lastReady = req_ready;
    @(posedge clk);
    if (r) begin
      modelValid = 1'b0;
      lastServed = N - 1;
      sb.delete();
    end else if (expReady != '0) begin
      sb.push_back('{data: refCvt(pd[g]), id: g});
      lastServed = g;
      modelValid = 1'b1;
    end else if (ordy) begin
      modelValid = 1'b0;
    end
    for (int i = 0; i < N; i++) if (lastReady[i]) pv[i] = 1'b0;
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(modelValid));
    if (r) begin
      checkOutput("reset_out_id", 32'(out_id), 32'd0);
      checkOutput("reset_out_data", out_data, 32'd0);
    end
  endtask

  task automatic directedCvt(input logic [15:0] h, input logic [31:0] expected);
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    pv[0] = 1'b1;
    pd[0] = h;
    applyStimulus(1'b0, 1'b1);
    checkOutput("cvt_const_data", out_data, expected);
    checkOutput("cvt_const_id", 32'(out_id), 32'd0);
  endtask

  task automatic setAll();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1;
      pd[i] = randHalf();
    end
  endtask

  task automatic clearAll();
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
  endtask

  // Monitor: every accepted output is popped from the scoreboard and compared
  always @(negedge clk) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
      if (sb.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_result: got 0x%08h id %0d, expected no result", out_data, out_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result_data", out_data, e.data);
        checkOutput("result_id", 32'(out_id), 32'(e.id));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    lastServed = N - 1;
    modelValid = 1'b0;
    clearAll();
    for (int i = 0; i < N; i++) pd[i] = '0;

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Round robin with everyone requesting: grants 0,1,2,3,0,1
    for (int c = 0; c < 6; c++) begin
      setAll();
      applyStimulus(1'b0, 1'b1);
      checkOutput("rr_grant", 32'(lastReady), 32'(1 << (c % N)));
    end

    // Backpressure: result pending, no grants, output stable
    setAll();
    applyStimulus(1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b0);
      if (sb.size() > 0) begin
        checkOutput("bp_data_stable", out_data, sb[0].data);
        checkOutput("bp_id_stable", 32'(out_id), 32'(sb[0].id));
      end
    end
    applyStimulus(1'b0, 1'b1);

    // Reset mid-stream with a result held, then first grant goes to req 0
    setAll();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    setAll();
    applyStimulus(1'b0, 1'b1);
    checkOutput("post_reset_grant", 32'(lastReady), 32'b0001);

    // Sparse: req 3 served, then only req 2 -> granted immediately
    clearAll();
    pv[3] = 1'b1;
    pd[3] = randHalf();
    applyStimulus(1'b0, 1'b1);
    pv[2] = 1'b1;
    pd[2] = randHalf();
    applyStimulus(1'b0, 1'b1);
    checkOutput("sparse_grant", 32'(lastReady), 32'b0100);

    // Directed conversions on requester 0
    directedCvt(16'h3C00, 32'h3F800000);
    directedCvt(16'hC000, 32'hC0000000);
    directedCvt(16'h7C00, 32'h7F800000);
    directedCvt(16'h7E01, 32'h7FC02000);
`ifdef FP16_SUBNORM_EN
    directedCvt(16'h0001, 32'h33800000);
`else
    directedCvt(16'h0001, 32'h00000000);
`endif
    directedCvt(16'h8000, 32'h80000000);

    // Randomized traffic with random backpressure and rare resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pd[i] = randHalf();
        end
      end
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
    end

    // Drain and confirm every expected result was delivered
    clearAll();
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
